relay_frame_ctrl: RTL and testbench

Parametrised successor to the HF relay mode controller. It samples the decoded relay symbol stream at a divided strobe and detects frame start and end patterns, byte-aligned, for both fake-reader and fake-tag roles. From these it drives the front-end mod_type, with a frame timeout and a carrier-quiet hold. It also captures a configurable number of frame bits into a buffer that the ARM drains over a valid/ready handshake. It sits between relay_decode (upstream) and the mod_type mux / SSP output (downstream).

---
 rtl/relay_pkg.sv | 39 +++
 rtl/relay_frame_ctrl_if.sv | 15 +
 rtl/relay_capture_buf.sv | 55 +++++
 rtl/relay_frame_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_relay_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/relay_pkg.sv
// relay_pkg: shared encodings for the relay frame controller.
//   - front-end mod_type codes driven towards the mod_type mux
//   - host mode codes
//   - default start/end patterns for the fake-reader and fake-tag roles
//   - FSM state type (also exported on the debug port)
//   - strobe_phase(): divider phase at which the symbol strobe fires
package relay_pkg;

    localparam logic [2:0] MT_SNIFFER       = 3'b000;
    localparam logic [2:0] MT_TAGSIM_LISTEN = 3'b001;
    localparam logic [2:0] MT_TAGSIM_MOD    = 3'b010;
    localparam logic [2:0] MT_READER_LISTEN = 3'b011;
    localparam logic [2:0] MT_READER_MOD    = 3'b100;

    localparam logic [2:0] MODE_FAKE_READER = 3'b101;
    localparam logic [2:0] MODE_FAKE_TAG    = 3'b110;
    localparam logic [2:0] MODE_DUMP        = 3'b111;

    localparam logic [3:0]  DEF_START_READER = 4'hc;
    localparam logic [3:0]  DEF_START_TAG    = 4'hf;
    localparam logic [15:0] DEF_END_READER_A = 16'h0000;
    localparam logic [15:0] DEF_END_READER_B = 16'hc000;
    localparam logic [15:0] DEF_END_TAG      = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LISTEN = 3'd1,
        ST_QUIET  = 3'd2,
        ST_MOD    = 3'd3,
        ST_DUMP   = 3'd4
    } state_t;

    // Strobe sits in the middle of the divided period so the symbol is
    // sampled away from its transitions.
    function automatic int unsigned strobe_phase(input int unsigned div_log2);
        return 32'd1 << (div_log2 - 32'd1);
    endfunction

endpackage

// File: rtl/relay_frame_ctrl_if.sv
// relay_frame_ctrl_if: capture drain handshake towards the ARM.
//   cap_bit   : capture data bit
//   cap_valid : a capture bit is presented
//   cap_ready : consumer accepts the presented bit
// Handshake: a bit transfers on the rising clk edge where cap_valid and
// cap_ready are both high. cap_valid never depends on cap_ready, and while
// cap_valid is high with cap_ready low, cap_bit holds its value.
interface relay_frame_ctrl_if;
    logic cap_bit;
    logic cap_valid;
    logic cap_ready;

    modport master (output cap_bit, output cap_valid, input cap_ready);
    modport slave  (input cap_bit, input cap_valid, output cap_ready);
endinterface

// File: rtl/relay_capture_buf.sv
// relay_capture_buf: CAP_DEPTH-bit frame capture buffer with drain port.
//   clk, reset   : clock, synchronous active-high reset
//   arm          : restart capture at bit 0 (frame start)
//   wr_en/wr_bit : write one bit while armed
//   drain_start  : rewind the read pointer (entering DUMP)
//   drain_en     : drain permitted (in DUMP)
//   cap          : valid/ready drain towards the ARM
module relay_capture_buf #(
    parameter int unsigned CAP_DEPTH = 80
) (
    input  logic clk,
    input  logic reset,
    input  logic arm,
    input  logic wr_en,
    input  logic wr_bit,
    input  logic drain_start,
    input  logic drain_en,
    relay_frame_ctrl_if.master cap
);
    localparam int unsigned PTR_W = $clog2(CAP_DEPTH + 1);

    logic [CAP_DEPTH-1:0] bits_q;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            bits_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            armed  <= 1'b0;
        end else begin
            if (arm) begin
                wr_ptr <= '0;
                armed  <= 1'b1;
            end else if (wr_en && armed) begin
                bits_q[wr_ptr] <= wr_bit;
                wr_ptr         <= wr_ptr + PTR_W'(1);
                // Last slot written: stop here, later bits are dropped.
                if (wr_ptr == PTR_W'(CAP_DEPTH - 1))
                    armed <= 1'b0;
            end
            if (drain_start)
                rd_ptr <= '0;
            else if (cap.cap_valid && cap.cap_ready)
                rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // wr_ptr doubles as the count of captured bits since it never wraps.
    assign cap.cap_valid = drain_en && (rd_ptr < wr_ptr);
    assign cap.cap_bit   = cap.cap_valid ? bits_q[rd_ptr] : 1'b0;

endmodule

// File: rtl/relay_frame_ctrl.sv
// relay_frame_ctrl: relay frame detector and front-end mode controller.
//   clk, reset   : clock, synchronous active-high reset
//   mode         : host mode (FAKE_READER / FAKE_TAG / DUMP / else SNIFFER)
//   sym_in       : decoded relay symbol
//   raw_active   : undecoded relay line, high when traffic is imminent
//   mod_type     : registered front-end mode code
//   data_out     : delayed symbol (window bit 3) for the modulator
//   frame_active : high while modulating a frame
//   timeout      : sticky frame-timeout flag
//   fsm_state    : current FSM state (debug)
//   cap          : capture drain handshake
module relay_frame_ctrl
    import relay_pkg::*;
#(
    parameter int unsigned      DIV_LOG2       = 4,
    parameter int unsigned      WIN_W          = 20,
    parameter logic [3:0]       START_READER   = DEF_START_READER,
    parameter logic [3:0]       START_TAG      = DEF_START_TAG,
    parameter int unsigned      END_W          = 16,
    parameter logic [END_W-1:0] END_READER_A   = DEF_END_READER_A,
    parameter logic [END_W-1:0] END_READER_B   = DEF_END_READER_B,
    parameter logic [END_W-1:0] END_TAG        = DEF_END_TAG,
    parameter int unsigned      MAX_FRAME_SYMS = 1024,
    parameter int unsigned      QUIET_SYMS     = 16,
    parameter int unsigned      CAP_DEPTH      = 80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] mode,
    input  logic       sym_in,
    input  logic       raw_active,
    output logic [2:0] mod_type,
    output logic       data_out,
    output logic       frame_active,
    output logic       timeout,
    output state_t     fsm_state,
    relay_frame_ctrl_if.master cap
);
    localparam int unsigned FS_W = $clog2(MAX_FRAME_SYMS);
    localparam int unsigned Q_W  = $clog2(QUIET_SYMS + 1);
    localparam logic [DIV_LOG2-1:0] PHASE = DIV_LOG2'(strobe_phase(DIV_LOG2));

    state_t              state, state_next;
    logic [DIV_LOG2-1:0] div_cnt;
    logic [WIN_W-1:0]    window;
    logic [2:0]          bit_cnt;
    logic [Q_W-1:0]      quiet_cnt;
    logic [FS_W-1:0]     frame_syms;
    logic [2:0]          mode_q;
    logic [2:0]          mod_type_next;

    logic             strobe, mode_chg, is_reader, is_tag;
    logic [WIN_W-1:0] window_shift;
    logic [3:0]       start_nib;
    logic             start_hit, end_hit, limit_hit, quiet_done;
    logic             start_take, timeout_set;
    logic [2:0]       listen_code, mod_code;

    assign strobe       = (div_cnt == PHASE);
    assign mode_chg     = (mode != mode_q);
    assign is_reader    = (mode == MODE_FAKE_READER);
    assign is_tag       = (mode == MODE_FAKE_TAG);
    assign window_shift = {window[WIN_W-2:0], sym_in};
    assign start_nib    = is_reader ? START_READER : START_TAG;
    assign listen_code  = is_reader ? MT_READER_LISTEN : (is_tag ? MT_TAGSIM_LISTEN : MT_SNIFFER);
    assign mod_code     = is_reader ? MT_READER_MOD : (is_tag ? MT_TAGSIM_MOD : MT_SNIFFER);

    // Pattern compares look at the window as it will be after this strobe.
    assign start_hit  = strobe && (is_reader || is_tag) &&
                        (window_shift == {{(WIN_W-4){1'b0}}, start_nib});
    // End patterns only count on a byte boundary of the frame.
    assign end_hit    = strobe && (bit_cnt == 3'd0) &&
                        (is_reader ? ((window_shift[END_W+3:0] == {END_READER_A, 4'b0000}) ||
                                      (window_shift[END_W+3:0] == {END_READER_B, 4'b0000}))
                                   : (window_shift[11:0] == {END_TAG[7:0], 4'b0000}));
    assign limit_hit  = strobe && (frame_syms == FS_W'(MAX_FRAME_SYMS - 1));
    assign quiet_done = strobe && !raw_active && (quiet_cnt == Q_W'(QUIET_SYMS - 1));

    always_comb begin
        state_next  = state;
        start_take  = 1'b0;
        timeout_set = 1'b0;
        if (mode_chg) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_reader || is_tag)  state_next = ST_LISTEN;
                    else if (mode == MODE_DUMP) state_next = ST_DUMP;
                end
                ST_LISTEN: begin
                    if (start_hit) begin
                        state_next = ST_MOD;
                        start_take = 1'b1;
                    end else if (raw_active) begin
                        state_next = ST_QUIET;
                    end
                end
                ST_QUIET: begin
                    if (start_hit) begin
                        state_next = ST_MOD;
                        start_take = 1'b1;
                    end else if (quiet_done) begin
                        state_next = ST_LISTEN;
                    end
                end
                ST_MOD: begin
                    // End match outranks the timeout on the same strobe.
                    if (end_hit) begin
                        state_next = ST_LISTEN;
                    end else if (limit_hit) begin
                        state_next  = ST_LISTEN;
                        timeout_set = 1'b1;
                    end
                end
                ST_DUMP:  state_next = ST_DUMP;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // mod_type is registered from the next state so it changes on the
    // same edge as the state itself.
    always_comb begin
        mod_type_next = MT_SNIFFER;
        case (state_next)
            ST_LISTEN: mod_type_next = listen_code;
            ST_MOD:    mod_type_next = mod_code;
            ST_DUMP:   mod_type_next = MT_READER_LISTEN;
            default:   mod_type_next = MT_SNIFFER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            div_cnt      <= '0;
            window       <= '0;
            bit_cnt      <= '0;
            quiet_cnt    <= '0;
            frame_syms   <= '0;
            mode_q       <= '0;
            mod_type     <= MT_SNIFFER;
            frame_active <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            div_cnt      <= div_cnt + DIV_LOG2'(1);
            mode_q       <= mode;
            state        <= state_next;
            mod_type     <= mod_type_next;
            frame_active <= (state_next == ST_MOD);

            if (mode_chg) begin
                window  <= '0;
                timeout <= 1'b0;
            end else begin
                if (strobe)      window  <= window_shift;
                if (timeout_set) timeout <= 1'b1;
            end

            if (start_take)  bit_cnt <= '0;
            else if (strobe) bit_cnt <= bit_cnt + 3'd1;

            // Any activity on the raw line restarts the quiet interval.
            if (state != ST_QUIET || raw_active) quiet_cnt <= '0;
            else if (strobe)                     quiet_cnt <= quiet_cnt + Q_W'(1);

            if (start_take)                     frame_syms <= '0;
            else if (strobe && state == ST_MOD) frame_syms <= frame_syms + FS_W'(1);
        end
    end

    assign data_out  = window[3];
    assign fsm_state = state;

    relay_capture_buf #(.CAP_DEPTH(CAP_DEPTH)) u_capture (
        .clk         (clk),
        .reset       (reset),
        .arm         (start_take),
        .wr_en       (strobe && (state == ST_MOD)),
        .wr_bit      (sym_in),
        .drain_start ((state != ST_DUMP) && (state_next == ST_DUMP)),
        .drain_en    (state == ST_DUMP),
        .cap         (cap)
    );

endmodule

// File: tb/tb_relay_frame_ctrl.sv
`timescale 1ns/1ps
module tb_relay_frame_ctrl;
    import relay_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] mode = 3'b000;
    logic       sym_in = 1'b0;
    logic       raw_active = 1'b0;
    logic [2:0] mod_type;
    logic       data_out, frame_active, timeout;
    state_t     fsm_state;

    relay_frame_ctrl_if cap_if();

    relay_frame_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .sym_in       (sym_in),
        .raw_active   (raw_active),
        .mod_type     (mod_type),
        .data_out     (data_out),
        .frame_active (frame_active),
        .timeout      (timeout),
        .fsm_state    (fsm_state),
        .cap          (cap_if)
    );

    always #5 clk = ~clk;

    // Independent strobe timing: the strobe edge is the posedge at which
    // this counter reads 8, counting from the last reset edge.
    logic [3:0] tb_div = 4'd0;
    always @(posedge clk) begin
        if (reset) tb_div <= 4'd0;
        else       tb_div <= tb_div + 4'd1;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [2:0] exp_mod_q[$];
    logic [0:0] exp_cap_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every mod_type change and every capture transfer pops the
    // next expected value.
    bit         mon_en = 1'b0;
    logic [2:0] prev_mod = 3'b000;
    bit         prev_stall = 1'b0;
    logic       prev_bit = 1'b0;
    int         xfer_cnt = 0;
    logic [2:0] e_mod;
    logic [0:0] e_cap;

    always @(negedge clk) begin
        if (mon_en) begin
            if (mod_type != prev_mod) begin
                if (exp_mod_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mod_type_change: got %0h with no change expected", mod_type);
                end else begin
                    e_mod = exp_mod_q.pop_front();
                    check("mod_type_change", 32'(mod_type), 32'(e_mod));
                end
            end
            if (prev_stall && cap_if.cap_valid)
                check("cap_bit_hold", 32'(cap_if.cap_bit), 32'(prev_bit));
            if (cap_if.cap_valid && cap_if.cap_ready) begin
                xfer_cnt++;
                if (exp_cap_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cap_xfer: got bit %0d with no bit expected", cap_if.cap_bit);
                end else begin
                    e_cap = exp_cap_q.pop_front();
                    check("cap_xfer", 32'(cap_if.cap_bit), 32'(e_cap));
                end
            end
        end
        prev_mod   = mod_type;
        prev_stall = cap_if.cap_valid && !cap_if.cap_ready;
        prev_bit   = cap_if.cap_bit;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Returns 2 ns after the next strobe edge.
    task automatic next_strobe();
        @(negedge clk);
        while (tb_div != 4'd8) @(negedge clk);
        @(posedge clk);
        #2;
    endtask

    task automatic send_sym(input logic b);
        sym_in = b;
        next_strobe();
    endtask

    task automatic pulse_raw();
        raw_active = 1'b1;
        @(posedge clk);
        #2;
        raw_active = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mod_type"},     32'(mod_type), 32'(MT_SNIFFER));
        check({tag, "_data_out"},     32'(data_out), 32'd0);
        check({tag, "_frame_active"}, 32'(frame_active), 32'd0);
        check({tag, "_timeout"},      32'(timeout), 32'd0);
        check({tag, "_cap_valid"},    32'(cap_if.cap_valid), 32'd0);
        check({tag, "_cap_bit"},      32'(cap_if.cap_bit), 32'd0);
        check({tag, "_state"},        32'(fsm_state), 32'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    int vcnt;
    logic b;

    initial begin
        cap_if.cap_ready = 1'b0;
        wait_clk(3);
        check_all_zero("reset");
        reset  = 1'b0;
        mon_en = 1'b1;

        // Reader start detection.
        exp_mod_q.push_back(MT_READER_LISTEN);
        mode = MODE_FAKE_READER;
        repeat (20) send_sym(1'b0);
        check("reader_listen", 32'(mod_type), 32'(MT_READER_LISTEN));
        send_sym(1'b1);
        send_sym(1'b1);
        send_sym(1'b0);
        exp_mod_q.push_back(MT_READER_MOD);
        send_sym(1'b0);
        check("reader_start_mod", 32'(mod_type), 32'(MT_READER_MOD));
        check("reader_start_active", 32'(frame_active), 32'd1);
        check("data_out_win3", 32'(data_out), 32'd1);

        // One data byte, then zeros. The 20-zero window first appears on
        // symbol 28 of the frame (not a byte boundary) and is only accepted
        // on symbol 33, where the byte counter is back at 0.
        repeat (8) send_sym(1'b1);
        for (int k = 1; k <= 24; k++) begin
            send_sym(1'b0);
            if (k == 20) check("end_misaligned_hold", 32'(mod_type), 32'(MT_READER_MOD));
        end
        check("end_before_boundary", 32'(mod_type), 32'(MT_READER_MOD));
        exp_mod_q.push_back(MT_READER_LISTEN);
        send_sym(1'b0);
        check("end_aligned_listen", 32'(mod_type), 32'(MT_READER_LISTEN));
        check("end_frame_inactive", 32'(frame_active), 32'd0);
        check("end_no_timeout", 32'(timeout), 32'd0);

        // Quiet hold: 16 quiet strobes return to LISTEN.
        exp_mod_q.push_back(MT_SNIFFER);
        pulse_raw();
        check("quiet_enter", 32'(mod_type), 32'(MT_SNIFFER));
        repeat (15) next_strobe();
        check("quiet_hold15", 32'(mod_type), 32'(MT_SNIFFER));
        exp_mod_q.push_back(MT_READER_LISTEN);
        next_strobe();
        check("quiet_exit16", 32'(mod_type), 32'(MT_READER_LISTEN));

        // Quiet restart: activity after 9 strobes restarts the count.
        exp_mod_q.push_back(MT_SNIFFER);
        pulse_raw();
        repeat (9) next_strobe();
        pulse_raw();
        repeat (15) next_strobe();
        check("quiet_restart_hold", 32'(mod_type), 32'(MT_SNIFFER));
        exp_mod_q.push_back(MT_READER_LISTEN);
        next_strobe();
        check("quiet_restart_exit", 32'(mod_type), 32'(MT_READER_LISTEN));

        // Capture a 100-symbol 1010... frame; only the first 80 survive.
        send_sym(1'b1);
        send_sym(1'b1);
        send_sym(1'b0);
        exp_mod_q.push_back(MT_READER_MOD);
        send_sym(1'b0);
        for (int i = 0; i < 100; i++) begin
            b = (i % 2 == 0);
            if (i < 80) exp_cap_q.push_back(b);
            send_sym(b);
        end
        check("capture_frame_mod", 32'(mod_type), 32'(MT_READER_MOD));

        // Drain in DUMP with cap_ready toggling.
        exp_mod_q.push_back(MT_SNIFFER);
        exp_mod_q.push_back(MT_READER_LISTEN);
        mode = MODE_DUMP;
        wait_clk(4);
        check("dump_code", 32'(mod_type), 32'(MT_READER_LISTEN));
        for (int i = 0; i < 400; i++) begin
            cap_if.cap_ready = ~cap_if.cap_ready;
            wait_clk(1);
        end
        cap_if.cap_ready = 1'b0;
        wait_clk(2);
        check("drain_count", 32'(xfer_cnt), 32'd80);
        check("drain_valid_low", 32'(cap_if.cap_valid), 32'd0);
        check("drain_queue_empty", 32'(exp_cap_q.size()), 32'd0);

        // Tag role: start 4'hf, then 1024 strobes without an end.
        exp_mod_q.push_back(MT_SNIFFER);
        exp_mod_q.push_back(MT_TAGSIM_LISTEN);
        mode = MODE_FAKE_TAG;
        repeat (16) send_sym(1'b0);
        check("tag_listen", 32'(mod_type), 32'(MT_TAGSIM_LISTEN));
        send_sym(1'b1);
        send_sym(1'b1);
        send_sym(1'b1);
        exp_mod_q.push_back(MT_TAGSIM_MOD);
        send_sym(1'b1);
        check("tag_start_mod", 32'(mod_type), 32'(MT_TAGSIM_MOD));
        repeat (1023) send_sym(1'b1);
        check("tag_pre_timeout_mod", 32'(mod_type), 32'(MT_TAGSIM_MOD));
        check("tag_pre_timeout_flag", 32'(timeout), 32'd0);
        exp_mod_q.push_back(MT_TAGSIM_LISTEN);
        send_sym(1'b1);
        check("tag_timeout_listen", 32'(mod_type), 32'(MT_TAGSIM_LISTEN));
        check("tag_timeout_flag", 32'(timeout), 32'd1);
        check("tag_timeout_inactive", 32'(frame_active), 32'd0);
        exp_mod_q.push_back(MT_SNIFFER);
        mode = 3'b000;
        wait_clk(3);
        check("timeout_cleared", 32'(timeout), 32'd0);

        // Reset in the middle of a reader frame.
        exp_mod_q.push_back(MT_READER_LISTEN);
        mode = MODE_FAKE_READER;
        repeat (16) send_sym(1'b0);
        send_sym(1'b1);
        send_sym(1'b1);
        send_sym(1'b0);
        exp_mod_q.push_back(MT_READER_MOD);
        send_sym(1'b0);
        repeat (5) send_sym(1'b1);
        check("pre_reset_mod", 32'(mod_type), 32'(MT_READER_MOD));
        exp_mod_q.push_back(MT_SNIFFER);
        reset = 1'b1;
        wait_clk(1);
        check_all_zero("midmod_reset");
        mode = MODE_DUMP;
        wait_clk(1);
        exp_mod_q.push_back(MT_READER_LISTEN);
        reset = 1'b0;
        wait_clk(4);
        check("dump_after_reset_code", 32'(mod_type), 32'(MT_READER_LISTEN));
        cap_if.cap_ready = 1'b1;
        vcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (cap_if.cap_valid) vcnt++;
        end
        cap_if.cap_ready = 1'b0;
        check("dump_after_reset_valid", 32'(vcnt), 32'd0);

        wait_clk(2);
        check("mod_queue_empty", 32'(exp_mod_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
